// File: rtl/video_stream_monitor.sv
// Receive-side video stream monitor: recovers active-pixel coordinates, measures line/frame
// geometry against the configured mode, and produces a per-frame checksum of the active pixels.
module video_stream_monitor #(
    parameter int   VGA_WIDTH = 12,
    parameter int   HSIZE     = 640,
    parameter int   HMAX      = 800,
    parameter int   VSIZE     = 480,
    parameter int   VMAX      = 525,
    parameter logic HSPP      = 1'b1,
    parameter logic VSPP      = 1'b1
) (
    input  logic                 clk_vga,
    input  logic                 reset_n,
    input  logic [7:0]           video_red,
    input  logic [7:0]           video_green,
    input  logic [7:0]           video_blue,
    input  logic                 video_hsync,
    input  logic                 video_vsync,
    input  logic                 video_de,
    input  logic                 clear_err,
    output logic                 pixel_valid,
    output logic [VGA_WIDTH-1:0] hpos,
    output logic [VGA_WIDTH-1:0] vpos,
    output logic                 locked,
    output logic                 frame_done,
    output logic [VGA_WIDTH-1:0] meas_htotal,
    output logic [VGA_WIDTH-1:0] meas_hactive,
    output logic [VGA_WIDTH-1:0] meas_vtotal,
    output logic [VGA_WIDTH-1:0] meas_vactive,
    output logic [31:0]          frame_checksum,
    output logic                 err_htotal,
    output logic                 err_hactive,
    output logic                 err_vtotal,
    output logic                 err_vactive
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [VGA_WIDTH-1:0] L_HSIZE = VGA_WIDTH'(HSIZE);
    localparam logic [VGA_WIDTH-1:0] L_HMAX  = VGA_WIDTH'(HMAX);
    localparam logic [VGA_WIDTH-1:0] L_VSIZE = VGA_WIDTH'(VSIZE);
    localparam logic [VGA_WIDTH-1:0] L_VMAX  = VGA_WIDTH'(VMAX);
    localparam logic [VGA_WIDTH-1:0] L_ONE   = VGA_WIDTH'(1);

    state_t r_state;
    state_t w_stateNext;
    logic   w_enterMeasure;

    logic [7:0] r_red;
    logic [7:0] r_green;
    logic [7:0] r_blue;
    logic       r_hs;
    logic       r_vs;
    logic       r_de;
    logic       r_hsPrev;
    logic       r_vsPrev;

    logic [VGA_WIDTH-1:0] r_hcnt;
    logic [VGA_WIDTH-1:0] r_deCnt;
    logic [VGA_WIDTH-1:0] r_lines;
    logic [VGA_WIDTH-1:0] r_vlines;
    logic [VGA_WIDTH-1:0] r_hposNext;
    logic [VGA_WIDTH-1:0] r_lastHtotal;
    logic [VGA_WIDTH-1:0] r_lastHactive;
    logic                 r_skipLen;
    logic                 r_frameBad;
    logic [31:0]          r_cs;

    logic                 w_hsEdge;
    logic                 w_vsEdge;
    logic                 w_checking;
    logic [VGA_WIDTH-1:0] w_lineLen;
    logic [VGA_WIDTH-1:0] w_lineDe;
    logic                 w_lineActive;
    logic                 w_lenErr;
    logic                 w_actErr;
    logic                 w_lineBad;
    logic [VGA_WIDTH-1:0] w_frameLines;
    logic [VGA_WIDTH-1:0] w_frameVlines;
    logic                 w_frameEnd;
    logic                 w_vtotErr;
    logic                 w_vactErr;
    logic                 w_frameBad;
    logic [31:0]          w_csNext;

    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            r_red    <= '0;
            r_green  <= '0;
            r_blue   <= '0;
            r_hs     <= 1'b0;
            r_vs     <= 1'b0;
            r_de     <= 1'b0;
            r_hsPrev <= 1'b0;
            r_vsPrev <= 1'b0;
        end else begin
            r_red    <= video_red;
            r_green  <= video_green;
            r_blue   <= video_blue;
            r_hs     <= video_hsync;
            r_vs     <= video_vsync;
            r_de     <= video_de;
            r_hsPrev <= r_hs;
            r_vsPrev <= r_vs;
        end
    end

    // A line or frame boundary that coincides with this cycle's edge still belongs to the
    // ending line/frame, so the "closing" values fold in the current cycle's contribution.
    assign w_hsEdge      = (r_hs == HSPP) && (r_hsPrev != HSPP);
    assign w_vsEdge      = (r_vs == VSPP) && (r_vsPrev != VSPP);
    assign w_checking    = (r_state != SEARCH);
    assign w_lineLen     = r_hcnt + L_ONE;
    assign w_lineDe      = r_deCnt + {{(VGA_WIDTH-1){1'b0}}, r_de};
    assign w_lineActive  = (w_lineDe != '0);
    assign w_lenErr      = w_hsEdge && w_checking && !r_skipLen && (w_lineLen != L_HMAX);
    assign w_actErr      = w_hsEdge && w_checking && w_lineActive && (w_lineDe != L_HSIZE);
    assign w_lineBad     = w_lenErr || w_actErr;
    assign w_frameLines  = r_lines + {{(VGA_WIDTH-1){1'b0}}, w_hsEdge};
    assign w_frameVlines = r_vlines + {{(VGA_WIDTH-1){1'b0}}, (w_hsEdge && w_lineActive)};
    assign w_frameEnd    = w_vsEdge && w_checking;
    assign w_vtotErr     = w_frameEnd && (w_frameLines != L_VMAX);
    assign w_vactErr     = w_frameEnd && (w_frameVlines != L_VSIZE);
    assign w_frameBad    = r_frameBad || w_lineBad || w_vtotErr || w_vactErr;
    assign w_csNext      = r_de ? ({r_cs[30:0], r_cs[31]} ^ {8'h00, r_red, r_green, r_blue}) : r_cs;

    always_comb begin
        w_stateNext    = r_state;
        w_enterMeasure = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_vsEdge) begin
                    w_stateNext    = MEASURE;
                    w_enterMeasure = 1'b1;
                end
            end
            MEASURE: begin
                if (w_vsEdge && !w_frameBad) begin
                    w_stateNext = LOCKED;
                end
            end
            LOCKED: begin
                if (w_lineBad || (w_vsEdge && w_frameBad)) begin
                    w_stateNext = MEASURE;
                end
            end
            default: w_stateNext = SEARCH;
        endcase
    end

    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_stateNext;
        end
    end

    assign locked = (r_state == LOCKED);

    // hcnt since reset is not a real line length, hence the first edge after SEARCH is not length-checked.
    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt        <= '0;
            r_deCnt       <= '0;
            r_lines       <= '0;
            r_vlines      <= '0;
            r_hposNext    <= '0;
            r_lastHtotal  <= '0;
            r_lastHactive <= '0;
            r_skipLen     <= 1'b0;
            r_frameBad    <= 1'b0;
            r_cs          <= '0;
        end else begin
            if (w_hsEdge) begin
                r_hcnt       <= '0;
                r_deCnt      <= '0;
                r_lastHtotal <= w_lineLen;
                if (w_lineActive) begin
                    r_lastHactive <= w_lineDe;
                end
            end else begin
                if (r_hcnt != '1) begin
                    r_hcnt <= r_hcnt + L_ONE;
                end
                if (r_de) begin
                    r_deCnt <= r_deCnt + L_ONE;
                end
            end
            if (w_vsEdge) begin
                r_lines    <= '0;
                r_vlines   <= '0;
                r_cs       <= '0;
                r_frameBad <= 1'b0;
            end else begin
                r_lines  <= w_frameLines;
                r_vlines <= w_frameVlines;
                r_cs     <= w_csNext;
                if (w_lineBad) begin
                    r_frameBad <= 1'b1;
                end
            end
            r_hposNext <= r_de ? (r_hposNext + L_ONE) : '0;
            if (w_enterMeasure) begin
                r_skipLen <= 1'b1;
            end else if (w_hsEdge) begin
                r_skipLen <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_vga or negedge reset_n) begin
        if (!reset_n) begin
            pixel_valid    <= 1'b0;
            hpos           <= '0;
            vpos           <= '0;
            frame_done     <= 1'b0;
            meas_htotal    <= '0;
            meas_hactive   <= '0;
            meas_vtotal    <= '0;
            meas_vactive   <= '0;
            frame_checksum <= '0;
            err_htotal     <= 1'b0;
            err_hactive    <= 1'b0;
            err_vtotal     <= 1'b0;
            err_vactive    <= 1'b0;
        end else begin
            pixel_valid <= r_de;
            hpos        <= r_de ? r_hposNext : '0;
            vpos        <= r_de ? r_vlines : '0;
            frame_done  <= w_frameEnd;
            if (w_frameEnd) begin
                meas_htotal    <= w_hsEdge ? w_lineLen : r_lastHtotal;
                meas_hactive   <= (w_hsEdge && w_lineActive) ? w_lineDe : r_lastHactive;
                meas_vtotal    <= w_frameLines;
                meas_vactive   <= w_frameVlines;
                frame_checksum <= w_csNext;
            end
            err_htotal  <= w_lenErr  || (err_htotal  && !clear_err);
            err_hactive <= w_actErr  || (err_hactive && !clear_err);
            err_vtotal  <= w_vtotErr || (err_vtotal  && !clear_err);
            err_vactive <= w_vactErr || (err_vactive && !clear_err);
        end
    end

endmodule

// File: tb/tb_video_stream_monitor.sv
// Bench for video_stream_monitor in a tiny 8x4 active / 12x6 total mode: a pixel scoreboard
// checks coordinates and latency, a frame scoreboard checks every frame_done.
module tb_video_stream_monitor;

    localparam int W = 12;

    typedef struct {
        logic [W-1:0] hpos;
        logic [W-1:0] vpos;
        int           stamp;
    } pixExp_t;

    typedef struct {
        logic [W-1:0] ht;
        logic [W-1:0] ha;
        logic [W-1:0] vt;
        logic [W-1:0] va;
        logic [31:0]  cs;
        logic         lk;
        logic [3:0]   errs;
    } frameExp_t;

    logic         clk_vga = 1'b0;
    logic         reset_n;
    logic [7:0]   video_red;
    logic [7:0]   video_green;
    logic [7:0]   video_blue;
    logic         video_hsync;
    logic         video_vsync;
    logic         video_de;
    logic         clear_err;
    logic         pixel_valid;
    logic [W-1:0] hpos;
    logic [W-1:0] vpos;
    logic         locked;
    logic         frame_done;
    logic [W-1:0] meas_htotal;
    logic [W-1:0] meas_hactive;
    logic [W-1:0] meas_vtotal;
    logic [W-1:0] meas_vactive;
    logic [31:0]  frame_checksum;
    logic         err_htotal;
    logic         err_hactive;
    logic         err_vtotal;
    logic         err_vactive;

    int        vectorCount = 0;
    int        miscompareCount = 0;
    int        cycleCnt = 0;
    int        probeCycle = -100;
    bit        skipPix = 1'b0;
    pixExp_t   pixQ[$];
    frameExp_t frameQ[$];

    video_stream_monitor #(
        .VGA_WIDTH(W), .HSIZE(8), .HMAX(12), .VSIZE(4), .VMAX(6), .HSPP(1'b1), .VSPP(1'b1)
    ) dut (
        .clk_vga(clk_vga), .reset_n(reset_n),
        .video_red(video_red), .video_green(video_green), .video_blue(video_blue),
        .video_hsync(video_hsync), .video_vsync(video_vsync), .video_de(video_de),
        .clear_err(clear_err),
        .pixel_valid(pixel_valid), .hpos(hpos), .vpos(vpos),
        .locked(locked), .frame_done(frame_done),
        .meas_htotal(meas_htotal), .meas_hactive(meas_hactive),
        .meas_vtotal(meas_vtotal), .meas_vactive(meas_vactive),
        .frame_checksum(frame_checksum),
        .err_htotal(err_htotal), .err_hactive(err_hactive),
        .err_vtotal(err_vtotal), .err_vactive(err_vactive)
    );

    always #5 clk_vga = ~clk_vga;

    always @(posedge clk_vga) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".pixel_valid"}, {31'd0, pixel_valid}, 32'd0);
        checkOutput({tag, ".pos"}, {8'd0, hpos, vpos}, 32'd0);
        checkOutput({tag, ".locked"}, {31'd0, locked}, 32'd0);
        checkOutput({tag, ".frame_done"}, {31'd0, frame_done}, 32'd0);
        checkOutput({tag, ".meas_h"}, {8'd0, meas_htotal, meas_hactive}, 32'd0);
        checkOutput({tag, ".meas_v"}, {8'd0, meas_vtotal, meas_vactive}, 32'd0);
        checkOutput({tag, ".checksum"}, frame_checksum, 32'd0);
        checkOutput({tag, ".errs"}, {28'd0, err_htotal, err_hactive, err_vtotal, err_vactive}, 32'd0);
    endtask

    function automatic frameExp_t mkExp(input int ht, input int ha, input int vt, input int va,
                                        input logic [31:0] cs, input logic lk, input logic [3:0] errs);
        frameExp_t f;
        f.ht   = W'(ht);
        f.ha   = W'(ha);
        f.vt   = W'(vt);
        f.va   = W'(va);
        f.cs   = cs;
        f.lk   = lk;
        f.errs = errs;
        return f;
    endfunction

    // Drives one 12x6 frame; hsync leads at column 9 and vsync rises together with hsync on line 4.
    task automatic applyStimulus(input int pixH, input int pixV, input logic [23:0] pixRgb,
                                 input int stretchLine, input int dropLine, input int probeLine,
                                 input int clearLine, input int resetLine,
                                 input bit expectDone, input frameExp_t fexp);
        int activeIdx;
        int lineLen;
        bit de;
        activeIdx = 0;
        for (int ln = 0; ln < 6; ln++) begin
            lineLen = (ln == stretchLine) ? 13 : 12;
            for (int hc = 0; hc < lineLen; hc++) begin
                @(posedge clk_vga);
                #1;
                if (ln == 0 && hc == 0) skipPix = 1'b0;
                de = (ln < 4) && (hc < 8) && (ln != dropLine);
                video_de    = de;
                video_hsync = (hc == 9) || (hc == 10);
                video_vsync = (ln == 4 && hc >= 9) || (ln == 5 && hc < 9);
                {video_red, video_green, video_blue} = (de && ln == pixV && hc == pixH) ? pixRgb : 24'h0;
                clear_err = (ln == clearLine) && (hc == 0);
                if (ln == resetLine && hc == 3) begin
                    reset_n = 1'b0;
                    skipPix = 1'b1;
                    pixQ.delete();
                    #1;
                    checkResetOutputs("midReset");
                end
                if (ln == resetLine && hc == 5) reset_n = 1'b1;
                if (de && !skipPix) pixQ.push_back('{hpos: W'(hc), vpos: W'(activeIdx), stamp: cycleCnt});
                if (ln == 4 && hc == 9 && expectDone) frameQ.push_back(fexp);
                if (ln == probeLine && hc == 9) probeCycle = cycleCnt;
            end
            if (ln < 4 && ln != dropLine) activeIdx++;
        end
        checkOutput("framePending", frameQ.size(), 0);
        checkOutput("pixPending", pixQ.size(), 0);
    endtask

    always @(negedge clk_vga) begin : monitor
        pixExp_t   p;
        frameExp_t f;
        if (pixel_valid && !skipPix) begin
            if (pixQ.size() == 0) begin
                checkOutput("pixUnexpected", 1, 0);
            end else begin
                p = pixQ.pop_front();
                checkOutput("hpos", hpos, p.hpos);
                checkOutput("vpos", vpos, p.vpos);
                checkOutput("pixLatency", cycleCnt - p.stamp, 2);
            end
        end
        if (frame_done) begin
            if (frameQ.size() == 0) begin
                checkOutput("doneUnexpected", 1, 0);
            end else begin
                f = frameQ.pop_front();
                checkOutput("meas_htotal", meas_htotal, f.ht);
                checkOutput("meas_hactive", meas_hactive, f.ha);
                checkOutput("meas_vtotal", meas_vtotal, f.vt);
                checkOutput("meas_vactive", meas_vactive, f.va);
                checkOutput("frame_checksum", frame_checksum, f.cs);
                checkOutput("lockedAtDone", locked, f.lk);
                checkOutput("errsAtDone", {err_htotal, err_hactive, err_vtotal, err_vactive}, f.errs);
            end
        end
        if (cycleCnt == probeCycle + 1) begin
            checkOutput("lockedBeforeDrop", locked, 1);
            checkOutput("errHtotalBeforeSet", err_htotal, 0);
        end
        if (cycleCnt == probeCycle + 2) begin
            checkOutput("lockedDrop", locked, 0);
            checkOutput("errHtotalSet", err_htotal, 1);
        end
    end

    initial begin
        frameExp_t none;
        none = mkExp(0, 0, 0, 0, 32'h0, 1'b0, 4'h0);
        reset_n     = 1'b0;
        video_red   = 8'h0;
        video_green = 8'h0;
        video_blue  = 8'h0;
        video_hsync = 1'b0;
        video_vsync = 1'b0;
        video_de    = 1'b0;
        clear_err   = 1'b0;
        repeat (3) @(posedge clk_vga);
        #1;
        checkResetOutputs("reset");
        reset_n = 1'b1;

        $display("[TB] acquisition from reset");
        applyStimulus(-1, -1, 24'h0, -1, -1, -1, -1, -1, 1'b0, none);
        applyStimulus(-1, -1, 24'h0, -1, -1, -1, -1, -1, 1'b1, mkExp(12, 8, 6, 4, 32'h0, 1'b1, 4'b0000));

        $display("[TB] checksum patterns");
        applyStimulus(7, 3, 24'h123456, -1, -1, -1, -1, -1, 1'b1, mkExp(12, 8, 6, 4, 32'h00123456, 1'b1, 4'b0000));
        applyStimulus(0, 0, 24'h000001, -1, -1, -1, -1, -1, 1'b1, mkExp(12, 8, 6, 4, 32'h80000000, 1'b1, 4'b0000));

        $display("[TB] stretched line, relock, clear_err");
        applyStimulus(-1, -1, 24'h0, 1, -1, 2, -1, -1, 1'b1, mkExp(12, 8, 6, 4, 32'h0, 1'b0, 4'b1000));
        applyStimulus(-1, -1, 24'h0, -1, -1, -1, -1, -1, 1'b1, mkExp(12, 8, 6, 4, 32'h0, 1'b1, 4'b1000));
        applyStimulus(-1, -1, 24'h0, -1, -1, -1, 0, -1, 1'b1, mkExp(12, 8, 6, 4, 32'h0, 1'b1, 4'b0000));

        $display("[TB] dropped active line");
        applyStimulus(-1, -1, 24'h0, -1, 2, -1, -1, -1, 1'b1, mkExp(12, 8, 6, 3, 32'h0, 1'b0, 4'b0001));
        applyStimulus(-1, -1, 24'h0, -1, -1, -1, -1, -1, 1'b1, mkExp(12, 8, 6, 4, 32'h0, 1'b1, 4'b0001));

        $display("[TB] reset mid-frame while locked");
        applyStimulus(-1, -1, 24'h0, -1, -1, -1, -1, 1, 1'b0, none);
        applyStimulus(-1, -1, 24'h0, -1, -1, -1, -1, -1, 1'b1, mkExp(12, 8, 6, 4, 32'h0, 1'b1, 4'b0000));

        repeat (4) @(posedge clk_vga);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
